// File: rtl/joy_db15_pkg.sv
// Shared types and constants for the DB15 splitter chain scanner:
// FSM states, per-player button indices and the 24-bit board bit map.
package joy_db15_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SKIP  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } joy_state_e;

    localparam int JOY_R      = 0;
    localparam int JOY_L      = 1;
    localparam int JOY_DN     = 2;
    localparam int JOY_UP     = 3;
    localparam int JOY_A      = 4;
    localparam int JOY_B      = 5;
    localparam int JOY_C      = 6;
    localparam int JOY_D      = 7;
    localparam int JOY_E      = 8;
    localparam int JOY_F      = 9;
    localparam int JOY_START  = 10;
    localparam int JOY_SELECT = 11;

    typedef struct packed {
        logic       player_sel;
        logic [3:0] button_idx;
    } joy_map_t;

    // Entry i describes chain bit i of one board; player_sel 0 = X, 1 = Y.
    localparam joy_map_t [23:0] BOARD_MAP = {
        {1'b1, 4'(JOY_A)},     {1'b1, 4'(JOY_B)},      {1'b1, 4'(JOY_C)},     {1'b1, 4'(JOY_D)},
        {1'b1, 4'(JOY_START)}, {1'b1, 4'(JOY_SELECT)}, {1'b1, 4'(JOY_E)},     {1'b1, 4'(JOY_F)},
        {1'b0, 4'(JOY_START)}, {1'b0, 4'(JOY_SELECT)}, {1'b0, 4'(JOY_E)},     {1'b0, 4'(JOY_F)},
        {1'b1, 4'(JOY_UP)},    {1'b1, 4'(JOY_DN)},     {1'b1, 4'(JOY_L)},     {1'b1, 4'(JOY_R)},
        {1'b0, 4'(JOY_UP)},    {1'b0, 4'(JOY_DN)},     {1'b0, 4'(JOY_L)},     {1'b0, 4'(JOY_R)},
        {1'b0, 4'(JOY_A)},     {1'b0, 4'(JOY_B)},      {1'b0, 4'(JOY_C)},     {1'b0, 4'(JOY_D)}
    };

    // Position in the packed joystick vector of a chain bit counted across all boards.
    function automatic int joy_pos(input int chain_bit);
        joy_map_t m;
        m = BOARD_MAP[5'(chain_bit % 24)];
        return 16 * (2 * (chain_bit / 24) + int'(m.player_sel)) + int'(m.button_idx);
    endfunction

endpackage

// File: rtl/joy_db15_chain_clkgen.sv
// Clock-enable divider: JOY_CLK toggles every CLK_DIV clk cycles and rise_o marks
// the clk cycle at whose end JOY_CLK goes 0->1.
module joy_db15_chain_clkgen #(
    parameter int CLK_DIV = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic joy_clk_o,
    output logic rise_o
);

    localparam int             DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          clk_q, clk_d;
    logic          rise_q, rise_d;

    // Divider wrap, JOY_CLK toggle and look-ahead of the rise strobe.
    always_comb begin
        div_d = div_q;
        clk_d = clk_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            clk_d = ~clk_q;
        end else begin
            div_d = div_q + DW'(1);
        end
        rise_d = (div_d == DIV_LAST) & ~clk_d;
    end

    // Divider state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q  <= '0;
            clk_q  <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            clk_q  <= clk_d;
            rise_q <= rise_d;
        end
    end

    assign joy_clk_o = clk_q;
    assign rise_o    = rise_q;

endmodule

// File: rtl/joy_db15_chain.sv
// Scanner for daisy-chained DB15 splitter boards; frames are captured into a shadow
// register and committed atomically. Define JOY_DB15_DEBOUNCE_EN to commit only on two equal frames.
module joy_db15_chain
    import joy_db15_pkg::*;
#(
    parameter int CLK_DIV    = 8,
    parameter int NUM_BOARDS = 1,
    parameter int FRAME_GAP  = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      JOY_CLK,
    output logic                      JOY_LOAD,
    input  logic                      JOY_DATA,
    output logic [32*NUM_BOARDS-1:0]  joystick,
    output logic                      frame_valid
);

    localparam int            CHAIN_BITS = 24 * NUM_BOARDS;
    localparam int            JW         = 32 * NUM_BOARDS;
    localparam int            PW         = $clog2(JW);
    localparam int            CW         = $clog2(CHAIN_BITS + 16);
    localparam logic [CW-1:0] LAST_BIT   = CW'(CHAIN_BITS - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(FRAME_GAP - 1);

    joy_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [JW-1:0] shadow_q, shadow_d;
    logic [JW-1:0] joy_q, joy_d;
    logic          load_q, load_d;
    logic          pend_q, pend_d;
    logic          valid_q, valid_d;
    logic [PW-1:0] pos_s;
    logic          rise_s;

    joy_db15_chain_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk_i     (clk),
        .rst_i     (reset),
        .joy_clk_o (JOY_CLK),
        .rise_o    (rise_s)
    );

    // Frame sequencer: state names the action taken at the next rise strobe.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        load_d   = load_q;
        pend_d   = 1'b0;
        pos_s    = '0;
        if (rise_s) begin
            case (state_q)
                ST_LOAD: begin
                    load_d   = 1'b0;
                    shadow_d = '0;
                    state_d  = ST_SKIP;
                end
                ST_SKIP: begin
                    load_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    for (int k = 0; k < CHAIN_BITS; k++) begin
                        pos_s = (cnt_q == CW'(k)) ? PW'(joy_pos(k)) : pos_s;
                    end
                    shadow_d[pos_s] = ~JOY_DATA;
                    if (cnt_q == LAST_BIT) begin
                        pend_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = (FRAME_GAP == 0) ? ST_LOAD : ST_GAP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = ST_LOAD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = ST_LOAD;
            endcase
        end else begin
            state_d = state_q;
        end
    end

`ifdef JOY_DB15_DEBOUNCE_EN
    logic [JW-1:0] prev_q, prev_d;
    logic          prev_ok_q, prev_ok_d;

    // Commit only when two consecutive captures agree.
    always_comb begin
        joy_d     = joy_q;
        valid_d   = 1'b0;
        prev_d    = prev_q;
        prev_ok_d = prev_ok_q;
        if (pend_q) begin
            prev_d    = shadow_q;
            prev_ok_d = 1'b1;
            if (prev_ok_q && (shadow_q == prev_q)) begin
                joy_d   = shadow_q;
                valid_d = 1'b1;
            end else begin
                joy_d = joy_q;
            end
        end else begin
            joy_d = joy_q;
        end
    end

    // Previous-capture registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q    <= '0;
            prev_ok_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            prev_ok_q <= prev_ok_d;
        end
    end
`else
    // Every completed frame is committed.
    always_comb begin
        joy_d   = joy_q;
        valid_d = 1'b0;
        if (pend_q) begin
            joy_d   = shadow_q;
            valid_d = 1'b1;
        end else begin
            joy_d = joy_q;
        end
    end
`endif

    // Sequencer, shadow and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_LOAD;
            cnt_q    <= '0;
            shadow_q <= '0;
            load_q   <= 1'b1;
            pend_q   <= 1'b0;
            joy_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            load_q   <= load_d;
            pend_q   <= pend_d;
            joy_q    <= joy_d;
            valid_q  <= valid_d;
        end
    end

    assign JOY_LOAD    = load_q;
    assign joystick    = joy_q;
    assign frame_valid = valid_q;

endmodule

// File: tb/tb_joy_db15_chain.sv
// Scoreboard bench: three DUT lanes with different parameters, each driven by a
// behavioural splitter chain and checked against a button-to-chain-bit reference.
module tb_joy_db15_chain;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    // Source chain bit (within a board) of each button index R,L,Dn,Up,A,B,C,D,E,F,Start,Select.
    localparam int XSRC [12] = '{4, 5, 6, 7, 3, 2, 1, 0, 13, 12, 15, 14};
    localparam int YSRC [12] = '{8, 9, 10, 11, 23, 22, 21, 20, 17, 16, 19, 18};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_joy(input logic [47:0] bits, input int nb);
        logic [63:0] w;
        w = '0;
        for (int p = 0; p < 2 * nb; p++) begin
            for (int btn = 0; btn < 12; btn++) begin
                int src;
                src = 24 * (p / 2) + (((p % 2) == 0) ? XSRC[btn] : YSRC[btn]);
                w[16 * p + btn] = bits[src];
            end
        end
        return w;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int CD         = (g == 2) ? 4 : 8;
        localparam int NB         = (g == 1) ? 2 : 1;
        localparam int GP         = (g == 2) ? 3 : 0;
        localparam int NBITS      = 24 * NB;
        localparam int FRAME_CLKS = (2 + NBITS + GP) * 2 * CD;
        localparam logic [47:0] MASK = (NB == 2) ? 48'hFFFF_FFFF_FFFF : 48'h0000_00FF_FFFF;

        logic            jclk, jload, fv;
        logic            jdata = 1'b1;
        logic [32*NB-1:0] joy;
        logic [63:0]     exp_q [$];
        logic [47:0]     script [32];
        int              k = -1;
        int              frames_done = 0;
        int              n_push = 0;
        int              n_pop = 0;
        bit              load_seen = 1'b0;

        joy_db15_chain #(.CLK_DIV(CD), .NUM_BOARDS(NB), .FRAME_GAP(GP)) dut (
            .clk         (clk),
            .reset       (rst),
            .JOY_CLK     (jclk),
            .JOY_LOAD    (jload),
            .JOY_DATA    (jdata),
            .joystick    (joy),
            .frame_valid (fv)
        );

        // Chain model and stimulus: picks a pattern per frame, shifts it out, predicts commits.
        initial begin
            logic [47:0] one, pat, vec, prev_vec;
            int          n, rep, cyc, load_len;
            bit          prev_load, prev_jclk, first_fall, prev_ok;
            one = 48'd1;
            script[0]  = 48'd0;
            script[1]  = one << 3;
            script[2]  = one << 3;
            script[3]  = one << 23;
            script[4]  = one << 23;
            script[5]  = one << 15;
            script[6]  = 48'd0;
            script[7]  = one << 15;
            script[8]  = one << 15;
            script[9]  = one << ((NB == 2) ? 34 : 12);
            script[10] = one << ((NB == 2) ? 34 : 12);
            n = 11;
            while (n < 32) begin
                if ($urandom_range(0, 2) == 0) pat = one << $urandom_range(0, NBITS - 1);
                else                           pat = 48'({$urandom, $urandom}) & MASK;
                rep = $urandom_range(1, 2);
                for (int r = 0; r < rep && n < 32; r++) begin
                    script[n] = pat;
                    n++;
                end
            end
            n = 0; vec = '0; prev_vec = '0; prev_ok = 1'b0;
            cyc = 0; load_len = 0; prev_load = 1'b1; prev_jclk = 1'b0; first_fall = 1'b1;
            forever begin
                @(posedge clk); #1;
                if (rst) begin
                    k = -1; cyc = 0; prev_load = 1'b1; prev_jclk = 1'b0;
                    first_fall = 1'b1; prev_ok = 1'b0; load_seen = 1'b0;
                end else begin
                    cyc++;
                    if (prev_load && !jload) begin
                        if (first_fall) check($sformatf("lane%0d_first_load", g), 64'(cyc), 64'(CD));
                        first_fall = 1'b0;
                        vec = script[n % 32];
                        n++;
                        k = -1; load_len = 0; load_seen = 1'b1;
                    end
                    if (!jload) load_len++;
                    if (!prev_load && jload) begin
                        check($sformatf("lane%0d_load_len", g), 64'(load_len), 64'(2 * CD));
                        k = 0;
                    end else if (!prev_jclk && jclk && k >= 0 && k < NBITS) begin
                        k++;
                        if (k == NBITS) begin
`ifdef JOY_DB15_DEBOUNCE_EN
                            if (prev_ok && vec == prev_vec) begin
                                exp_q.push_back(ref_joy(vec, NB));
                                n_push++;
                            end
                            prev_vec = vec;
                            prev_ok  = 1'b1;
`else
                            exp_q.push_back(ref_joy(vec, NB));
                            n_push++;
`endif
                            frames_done++;
                        end
                    end
                    prev_load = jload;
                    prev_jclk = jclk;
                end
                jdata = (k >= 0 && k < NBITS) ? ~vec[6'(k)] : 1'b1;
            end
        end

        // Monitor: pops the scoreboard on every frame_valid and checks frame spacing.
        initial begin
            int cyc, last;
            bit have_last;
            cyc = 0; last = 0; have_last = 1'b0;
            forever begin
                @(negedge clk);
                cyc++;
                if (rst) begin
                    have_last = 1'b0;
                end else if (fv) begin
                    check($sformatf("lane%0d_load_before_valid", g), 64'(load_seen), 64'd1);
`ifndef JOY_DB15_DEBOUNCE_EN
                    if (have_last) check($sformatf("lane%0d_frame_period", g), 64'(cyc - last), 64'(FRAME_CLKS));
`endif
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL lane%0d_unexpected_valid: got frame_valid with joystick %h, expected no commit", g, joy);
                    end else begin
                        check($sformatf("lane%0d_joystick", g), 64'(joy), exp_q.pop_front());
                    end
                    n_pop++;
                    last = cyc;
                    have_last = 1'b1;
                end
            end
        end

        // Output state right after reset assertion.
        initial begin
            forever begin
                @(posedge rst); #1;
                check($sformatf("lane%0d_rst_joystick", g), 64'(joy), 64'd0);
                check($sformatf("lane%0d_rst_valid", g), 64'(fv), 64'd0);
                check($sformatf("lane%0d_rst_jclk", g), 64'(jclk), 64'd0);
                check($sformatf("lane%0d_rst_jload", g), 64'(jload), 64'd1);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        t = 0;
        while (lane[0].frames_done < 12 && t < 20000) begin @(negedge clk); t++; end
        check("wait_frames_pre_reset", 64'(lane[0].frames_done >= 12), 64'd1);
        t = 0;
        while (lane[0].k != 12 && t < 2000) begin @(negedge clk); t++; end
        check("wait_shift_bit12", 64'(lane[0].k), 64'd12);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        t = 0;
        while ((lane[0].frames_done < 26 || lane[1].frames_done < 26 || lane[2].frames_done < 26)
               && t < 40000) begin
            @(negedge clk);
            t++;
        end
        check("wait_frames_final", 64'(t < 40000), 64'd1);
        repeat (5) @(negedge clk);
        check("lane0_drain", 64'(lane[0].n_pop), 64'(lane[0].n_push));
        check("lane1_drain", 64'(lane[1].n_pop), 64'(lane[1].n_push));
        check("lane2_drain", 64'(lane[2].n_pop), 64'(lane[2].n_push));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
